fetch_unit: RTL and testbench

- Instruction fetch stage between the imem syncram and the processor decode logic.
- Owns the PC and drives address_imem.
- Absorbs the imem's one-cycle read latency with a small instruction buffer.
- Presents a valid/stall stream of (inst, inst_pc) to decode and accepts branch/jump redirects.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: imem address/data, decode-side instruction stream and redirect.
// master = fetch_unit side, slave = imem/decode side. dbg_count exposes buffer occupancy.
interface fetch_unit_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] address_imem;
  logic [DATA_WIDTH-1:0] q_imem;
  logic                  stall;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  inst_valid;
  logic [DATA_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic [CNT_W-1:0]      dbg_count;

  // Handshake: an instruction transfers on a cycle where inst_valid=1 and stall=0,
  // unless redirect_valid=1 in that cycle (the redirect discards it instead).
  modport master (
    output address_imem, inst_valid, inst, inst_pc, dbg_count,
    input  q_imem, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  address_imem, inst_valid, inst, inst_pc, dbg_count,
    output q_imem, stall, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, absorbs the imem one-cycle latency in a small FIFO.
// Optional FETCH_BYPASS_EN forwards q_imem straight to decode when the FIFO is empty.
module fetch_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH  = 2
) (
  input  logic         clock,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic                  pend_valid;
  logic [DATA_WIDTH-1:0] buf_inst [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [BUF_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic            flush;
  logic            head_valid;
  logic            bypass_sel;
  logic            out_valid;
  logic            pop;
  logic            pop_buf;
  logic            push;
  logic            issue;
  logic [CNT_W:0]  occupancy;

  always_comb begin
    flush      = reset | bus.redirect_valid;
    head_valid = (count != '0);
`ifdef FETCH_BYPASS_EN
    bypass_sel = ~head_valid & pend_valid & ~flush;
`else
    bypass_sel = 1'b0;
`endif
    out_valid  = ~reset & (head_valid | bypass_sel);
    pop        = out_valid & ~bus.stall;
    // Slots still committed after this edge; issuing is safe only while one is free.
    occupancy  = {1'b0, count} + (CNT_W+1)'(pend_valid) - (CNT_W+1)'(pop);
    issue      = ~flush & (occupancy < (CNT_W+1)'(BUF_DEPTH));
    push       = pend_valid & ~flush & ~(bypass_sel & pop);
    pop_buf    = pop & ~flush & head_valid;
  end

  always_comb begin
    bus.address_imem = reset ? RESET_PC : fetch_pc;
    bus.inst_valid   = out_valid;
    bus.dbg_count    = count;
    bus.inst         = '0;
    bus.inst_pc      = '0;
    if (out_valid) begin
      if (bypass_sel) begin
        bus.inst    = bus.q_imem;
        bus.inst_pc = pend_pc;
      end else begin
        bus.inst    = buf_inst[rd_ptr];
        bus.inst_pc = buf_pc[rd_ptr];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (bus.redirect_valid)
        fetch_pc <= bus.redirect_pc;
      else if (issue)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(1);

      pend_valid <= issue;
      if (issue)
        pend_pc <= fetch_pc;

      if (bus.redirect_valid) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push)
          wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_buf)
          rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop_buf);
      end
    end
  end

  // Storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      buf_inst[wr_ptr] <= bus.q_imem;
      buf_pc[wr_ptr]   <= pend_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios push expected (pc, inst) into a queue,
// a negedge monitor pops and compares every instruction that decode consumes.
module tb_fetch_unit;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BD = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUF_DEPTH(BD)) bus ();

  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC('0), .BUF_DEPTH(BD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  // imem syncram model: data for last cycle's address
  always @(posedge clock) bus.q_imem <= 32'h1000_0000 | 32'(bus.address_imem);

  int compared   = 0;
  int mismatched = 0;
  int pops       = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [AW+DW-1:0] model(input logic [AW-1:0] pc);
    return {pc, 32'h1000_0000 | 32'(pc)};
  endfunction

  task automatic push_seq(input logic [AW-1:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(model(start + AW'(i)));
  endtask

  // Monitor: every consumed instruction must match the head of the expected queue
  always @(negedge clock) begin
    logic [AW+DW-1:0] exp;
    if (!reset && !bus.redirect_valid) begin
      if (bus.inst_valid && !bus.stall) begin
        pops++;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pop: got pc 0x%0h, required no output at %0t", bus.inst_pc, $time);
        end else begin
          exp = exp_q.pop_front();
          check("pop_pc", 32'(bus.inst_pc), 32'(exp[AW+DW-1:DW]));
          check("pop_inst", bus.inst, exp[DW-1:0]);
        end
      end else if (!bus.inst_valid) begin
        check("empty_inst", bus.inst, 32'h0);
        check("empty_pc", 32'(bus.inst_pc), 32'h0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the bench 2 time units into C0 with reset low
  task automatic do_reset();
    exp_q.delete();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    @(negedge clock);
    check("rst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_pc", 32'(bus.inst_pc), 32'h0);
    check("rst_addr", 32'(bus.address_imem), 32'h0);
    step();
    reset = 1'b0;
    #1;
    check("c0_valid", 32'(bus.inst_valid), 32'h0);
    check("c0_inst", bus.inst, 32'h0);
    check("c0_pc", 32'(bus.inst_pc), 32'h0);
    check("c0_addr", 32'(bus.address_imem), 32'h0);
  endtask

  task automatic do_redirect(input logic [AW-1:0] pc);
    exp_q.delete();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  // Release stall, consume n instructions, check first-valid latency and no gaps
  task automatic stream(input int n, input int lat, input bit hold);
    int k = 0;
    int base = pops;
    bus.stall = 1'b0;
    while ((pops - base) < n && k < 100) begin
      @(negedge clock);
      if (k < lat) check("lat_idle", 32'(bus.inst_valid), 32'h0);
      else if (k == lat) check("lat_first", 32'(bus.inst_valid), 32'h1);
      step();
      k++;
    end
    check("stream_cycles", 32'(k), 32'(lat + n));
    if (hold) bus.stall = 1'b1;
  endtask

  task automatic fill_check();
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      if (s == 2) check("full_count", 32'(bus.dbg_count), 32'd2);
      step();
    end
  endtask

  initial begin
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clock);
    #1;

    // 1: reset latency and 20 contiguous instructions
    do_reset();
    push_seq(12'h000, 20);
    stream(20, LAT, 1'b1);

    // 2: stall with head at PC 4, then resume without gaps
    do_reset();
    push_seq(12'h000, 4);
    stream(4, LAT, 1'b1);
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      if (s >= 2) begin
        check("stall_pc", 32'(bus.inst_pc), 32'h4);
        check("stall_valid", 32'(bus.inst_valid), 32'h1);
        check("stall_count", 32'(bus.dbg_count), 32'd2);
        check("stall_addr", 32'(bus.address_imem), 32'h6);
      end
      step();
    end
    push_seq(12'h004, 4);
    stream(4, 0, 1'b1);

    // 3: redirect while streaming with head at PC 5
    do_reset();
    push_seq(12'h000, 5);
    stream(5, LAT, 1'b0);
    do_redirect(12'h100);
    push_seq(12'h100, 3);
    stream(3, LAT, 1'b1);

    // 4: PC wrap
    do_redirect(12'hFFE);
    push_seq(12'hFFE, 4);
    stream(4, LAT, 1'b1);

    // 5: reset with full FIFO under stall
    fill_check();
    do_reset();
    push_seq(12'h000, 4);
    stream(4, LAT, 1'b1);

    // 5b: redirect with full FIFO under stall
    fill_check();
    do_redirect(12'h100);
    push_seq(12'h100, 3);
    stream(3, LAT, 1'b1);

    // back-to-back redirects: last one wins
    do_redirect(12'h200);
    do_redirect(12'h300);
    push_seq(12'h300, 3);
    stream(3, LAT, 1'b1);

    repeat (3) step();
    check("leftover_expected", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
